des_operand_sequencer: RTL

Sits directly downstream of the hex-digit entry stage and upstream of the DES round core. Captures two consecutive 16-digit entries: first the data block, then the key. It launches the DES core with a one-cycle start pulse, waits for completion or timeout, and holds the 64-bit result for display until restart.

---
 rtl/des_seq_pkg.sv | 29 ++
 rtl/des_operand_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/des_seq_pkg.sv
// Shared types and constants for the DES operand sequencer.
// key_parity_ok is used only when KEY_PARITY_CHECK_EN is defined.
package des_seq_pkg;

    localparam int DES_WORD_W      = 64;
    localparam int DIGITS_PER_WORD = 16;

    typedef enum logic [2:0] {
        ST_GET_DATA = 3'b000,
        ST_WAIT_CLR = 3'b001,
        ST_GET_KEY  = 3'b010,
        ST_LAUNCH   = 3'b011,
        ST_BUSY     = 3'b100,
        ST_DONE     = 3'b101,
        ST_ERROR    = 3'b110,
        ST_UNUSED   = 3'b111
    } seq_state_e;

    // DES keys carry odd parity in every byte.
    function automatic logic key_parity_ok(input logic [DES_WORD_W-1:0] key);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DES_WORD_W / 8; i++) begin
            ok = ok & (^key[i*8 +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_operand_sequencer.sv
// Captures a data block and then a key from the entry stage, launches the DES core,
// and holds its result. Optional macro KEY_PARITY_CHECK_EN rejects keys with bad parity.
module des_operand_sequencer
    import des_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DES_WORD_W-1:0] entry_value,
    input  logic [4:0]            entry_count,
    input  logic                  decrypt_sw,
    input  logic                  restart_n,
    output logic                  des_start,
    output logic                  des_decrypt,
    output logic [DES_WORD_W-1:0] des_data,
    output logic [DES_WORD_W-1:0] des_key,
    input  logic                  des_done,
    input  logic [DES_WORD_W-1:0] des_result,
    output logic [DES_WORD_W-1:0] result,
    output logic                  result_valid,
    output logic                  error,
    output logic [2:0]            phase
);

    localparam logic [4:0]       FULL_COUNT = 5'(DIGITS_PER_WORD);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [4:0]            count_prev_q, count_prev_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DES_WORD_W-1:0] des_data_q, des_data_d;
    logic [DES_WORD_W-1:0] des_key_q, des_key_d;
    logic [DES_WORD_W-1:0] result_q, result_d;
    logic                  des_decrypt_q, des_decrypt_d;
    logic                  des_start_q, des_start_d;
    logic                  result_valid_q, result_valid_d;
    logic                  error_q, error_d;
    logic                  capture_s;

    // A word is complete only on the cycle the digit count first reaches full.
    assign capture_s = (count_prev_q != FULL_COUNT) && (entry_count == FULL_COUNT);

    // Next-state and datapath update logic.
    always_comb begin
        state_d        = state_q;
        count_prev_d   = entry_count;
        cnt_d          = cnt_q;
        des_data_d     = des_data_q;
        des_key_d      = des_key_q;
        result_d       = result_q;
        des_decrypt_d  = des_decrypt_q;
        des_start_d    = 1'b0;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        if (!restart_n) begin
            state_d        = ST_GET_DATA;
            result_valid_d = 1'b0;
            error_d        = 1'b0;
        end else begin
            case (state_q)
                ST_GET_DATA: begin
                    if (capture_s) begin
                        des_data_d = entry_value;
                        state_d    = ST_WAIT_CLR;
                    end else begin
                        state_d = ST_GET_DATA;
                    end
                end
                ST_WAIT_CLR: begin
                    if (entry_count == 5'd0) begin
                        state_d = ST_GET_KEY;
                    end else begin
                        state_d = ST_WAIT_CLR;
                    end
                end
                ST_GET_KEY: begin
                    if (capture_s) begin
                        des_key_d = entry_value;
`ifdef KEY_PARITY_CHECK_EN
                        if (!key_parity_ok(entry_value)) begin
                            error_d = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            des_decrypt_d = decrypt_sw;
                            des_start_d   = 1'b1;
                            state_d       = ST_LAUNCH;
                        end
`else
                        des_decrypt_d = decrypt_sw;
                        des_start_d   = 1'b1;
                        state_d       = ST_LAUNCH;
`endif
                    end else begin
                        state_d = ST_GET_KEY;
                    end
                end
                ST_LAUNCH: begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (des_done) begin
                        result_d       = des_result;
                        result_valid_d = 1'b1;
                        state_d        = ST_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                ST_ERROR: begin
                    result_valid_d = 1'b0;
                    state_d        = ST_ERROR;
                end
                default: begin
                    state_d = ST_GET_DATA;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_GET_DATA;
            count_prev_q   <= 5'd0;
            cnt_q          <= {CNT_W{1'b0}};
            des_data_q     <= {DES_WORD_W{1'b0}};
            des_key_q      <= {DES_WORD_W{1'b0}};
            result_q       <= {DES_WORD_W{1'b0}};
            des_decrypt_q  <= 1'b0;
            des_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_prev_q   <= count_prev_d;
            cnt_q          <= cnt_d;
            des_data_q     <= des_data_d;
            des_key_q      <= des_key_d;
            result_q       <= result_d;
            des_decrypt_q  <= des_decrypt_d;
            des_start_q    <= des_start_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    assign des_start    = des_start_q;
    assign des_decrypt  = des_decrypt_q;
    assign des_data     = des_data_q;
    assign des_key      = des_key_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign phase        = state_q;

endmodule
